// File: rtl/wb_regfile.sv
// Write-back result select, 32 x WIDTH architectural register file with two
// combinational read ports, plus commit counter and last-write record.
// Optional same-cycle write-through bypass on the read ports: define WBRF_BYPASS_EN.
module wb_regfile #(
  parameter int WIDTH = 32
) (
  input  logic             WBRF_CLK,
  input  logic             WBRF_RST,
  input  logic [WIDTH-1:0] WBRF_AluOutW,
  input  logic [WIDTH-1:0] WBRF_ReadDataW,
  input  logic [4:0]       WBRF_WriteRegW,
  input  logic             WBRF_RegWriteW,
  input  logic             WBRF_MemToRegW,
  input  logic [4:0]       WBRF_A1,
  input  logic [4:0]       WBRF_A2,
  output logic [WIDTH-1:0] WBRF_RD1,
  output logic [WIDTH-1:0] WBRF_RD2,
  output logic [WIDTH-1:0] WBRF_ResultW,
  output logic [4:0]       WBRF_LastWriteReg,
  output logic             WBRF_LastWriteValid,
  output logic [31:0]      WBRF_WriteCount
);

  logic [WIDTH-1:0] regs [32];
  logic [4:0]       last_write_reg;
  logic             last_write_valid;
  logic [31:0]      write_count;
  logic             commit;
  logic             bypass1;
  logic             bypass2;

  assign WBRF_ResultW = WBRF_MemToRegW ? WBRF_ReadDataW : WBRF_AluOutW;

  // $0 is hardwired: writes to it never commit, whatever MemToRegW says
  assign commit = WBRF_RegWriteW && (WBRF_WriteRegW != 5'd0);

  always_ff @(posedge WBRF_CLK) begin
    if (WBRF_RST) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
      last_write_reg   <= 5'd0;
      last_write_valid <= 1'b0;
      write_count      <= 32'd0;
    end else if (commit) begin
      regs[WBRF_WriteRegW] <= WBRF_ResultW;
      last_write_reg       <= WBRF_WriteRegW;
      last_write_valid     <= 1'b1;
      write_count          <= write_count + 32'd1;
    end
  end

`ifdef WBRF_BYPASS_EN
  assign bypass1 = commit && (WBRF_WriteRegW == WBRF_A1);
  assign bypass2 = commit && (WBRF_WriteRegW == WBRF_A2);
`else
  assign bypass1 = 1'b0;
  assign bypass2 = 1'b0;
`endif

  always_comb begin
    WBRF_RD1 = regs[WBRF_A1];
    if (WBRF_A1 == 5'd0) begin
      WBRF_RD1 = '0;
    end else if (bypass1) begin
      WBRF_RD1 = WBRF_ResultW;
    end
  end

  always_comb begin
    WBRF_RD2 = regs[WBRF_A2];
    if (WBRF_A2 == 5'd0) begin
      WBRF_RD2 = '0;
    end else if (bypass2) begin
      WBRF_RD2 = WBRF_ResultW;
    end
  end

  assign WBRF_LastWriteReg   = last_write_reg;
  assign WBRF_LastWriteValid = last_write_valid;
  assign WBRF_WriteCount     = write_count;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: behavioural register-file model compared
// every cycle, plus directed literal checks and randomized traffic.
module tb_wb_regfile;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] alu_out;
  logic [WIDTH-1:0] read_data;
  logic [4:0]       write_reg;
  logic             reg_write;
  logic             mem_to_reg;
  logic [4:0]       a1;
  logic [4:0]       a2;
  logic [WIDTH-1:0] rd1;
  logic [WIDTH-1:0] rd2;
  logic [WIDTH-1:0] result;
  logic [4:0]       last_reg;
  logic             last_valid;
  logic [31:0]      wcount;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] m_regs [32];
  logic [4:0]       m_last = 5'd0;
  logic             m_valid = 1'b0;
  logic [31:0]      m_count = 32'd0;
  bit               m_init = 1'b0;

  wb_regfile #(.WIDTH(WIDTH)) dut (
    .WBRF_CLK            (clk),
    .WBRF_RST            (rst),
    .WBRF_AluOutW        (alu_out),
    .WBRF_ReadDataW      (read_data),
    .WBRF_WriteRegW      (write_reg),
    .WBRF_RegWriteW      (reg_write),
    .WBRF_MemToRegW      (mem_to_reg),
    .WBRF_A1             (a1),
    .WBRF_A2             (a2),
    .WBRF_RD1            (rd1),
    .WBRF_RD2            (rd2),
    .WBRF_ResultW        (result),
    .WBRF_LastWriteReg   (last_reg),
    .WBRF_LastWriteValid (last_valid),
    .WBRF_WriteCount     (wcount)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] m_result();
    return mem_to_reg ? read_data : alu_out;
  endfunction

  function automatic logic [WIDTH-1:0] m_read(input logic [4:0] addr);
    if (addr == 5'd0) return '0;
`ifdef WBRF_BYPASS_EN
    if (reg_write && write_reg != 5'd0 && write_reg == addr) return m_result();
`endif
    return m_regs[addr];
  endfunction

  // Model state advances on each rising edge from the inputs present in that cycle
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_last  = 5'd0;
      m_valid = 1'b0;
      m_count = 32'd0;
      m_init  = 1'b1;
    end else if (reg_write && write_reg != 5'd0) begin
      m_regs[write_reg] = m_result();
      m_last  = write_reg;
      m_valid = 1'b1;
      m_count = m_count + 32'd1;
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      check("ResultW", result, m_result());
      check("RD1", rd1, m_read(a1));
      check("RD2", rd2, m_read(a2));
      check("LastWriteReg", {27'd0, last_reg}, {27'd0, m_last});
      check("LastWriteValid", {31'd0, last_valid}, {31'd0, m_valid});
      check("WriteCount", wcount, m_count);
    end
  end

  task automatic drive(input logic r, input logic we, input logic m2r, input logic [4:0] wr,
                       input logic [31:0] alu, input logic [31:0] rdat,
                       input logic [4:0] ra1, input logic [4:0] ra2);
    rst        = r;
    reg_write  = we;
    mem_to_reg = m2r;
    write_reg  = wr;
    alu_out    = alu;
    read_data  = rdat;
    a1         = ra1;
    a2         = ra2;
  endtask

  task automatic to_negedge();
    @(negedge clk);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b1, 1'b1, 1'b0, 5'd5, 32'h1234, 32'h0, 5'd5, 5'd0);
    next_cycle();
    next_cycle();

    // Reset held two cycles with a write pending: nothing must survive
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd5, 5'd0);
    to_negedge();
    check("reset_rd1", rd1, 32'h0);
    check("reset_count", wcount, 32'h0);
    check("reset_valid", {31'd0, last_valid}, 32'h0);
    next_cycle();

    drive(1'b0, 1'b1, 1'b0, 5'd8, 32'hDEADBEEF, 32'h0, 5'd0, 5'd0);
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd8, 5'd0);
    to_negedge();
    check("alu_rd1", rd1, 32'hDEADBEEF);
    check("alu_count", wcount, 32'd1);
    check("alu_last", {27'd0, last_reg}, 32'd8);
    next_cycle();

    drive(1'b0, 1'b1, 1'b1, 5'd9, 32'hFFFFFFFF, 32'h0000CAFE, 5'd0, 5'd0);
    to_negedge();
    check("load_result", result, 32'h0000CAFE);
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd9);
    to_negedge();
    check("load_rd2", rd2, 32'h0000CAFE);
    next_cycle();

    drive(1'b0, 1'b1, 1'b0, 5'd0, 32'h55, 32'h0, 5'd0, 5'd0);
    to_negedge();
    check("zero_rd1", rd1, 32'h0);
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0);
    to_negedge();
    check("zero_count", wcount, 32'd2);
    check("zero_last", {27'd0, last_reg}, 32'd9);
    next_cycle();

    drive(1'b0, 1'b1, 1'b0, 5'd3, 32'h11, 32'h0, 5'd0, 5'd0);
    next_cycle();
    drive(1'b0, 1'b1, 1'b0, 5'd3, 32'h22, 32'h0, 5'd3, 5'd3);
    to_negedge();
`ifdef WBRF_BYPASS_EN
    check("bypass_rd1", rd1, 32'h22);
    check("bypass_rd2", rd2, 32'h22);
`else
    check("nobypass_rd1", rd1, 32'h11);
    check("nobypass_rd2", rd2, 32'h11);
`endif
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd3, 5'd3);
    to_negedge();
    check("after_bypass_rd1", rd1, 32'h22);
    next_cycle();

    // Randomized traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 7), 1'($urandom),
            5'($urandom), $urandom, $urandom, 5'($urandom), 5'($urandom));
      if ($urandom_range(0, 7) == 0) a1 = write_reg;
      if ($urandom_range(0, 7) == 0) a2 = write_reg;
      next_cycle();
    end

    // Counter wrap: preload the counter just below rollover
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0);
    force dut.write_count = 32'hFFFFFFFF;
    m_count = 32'hFFFFFFFF;
    to_negedge();
    release dut.write_count;
    next_cycle();
    drive(1'b0, 1'b1, 1'b0, 5'd7, 32'hA5A5, 32'h0, 5'd0, 5'd0);
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd7, 5'd0);
    to_negedge();
    check("wrap_count", wcount, 32'h0);
    check("wrap_rd1", rd1, 32'hA5A5);
    next_cycle();

    drive(1'b1, 1'b1, 1'b0, 5'd4, 32'h77, 32'h0, 5'd0, 5'd0);
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd4, 5'd0);
    to_negedge();
    check("collide_rd1", rd1, 32'h0);
    check("collide_count", wcount, 32'h0);
    next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Write-back stage and architectural register file of the pipelined MIPS core; it consumes the W-stage outputs of the memory-to-write-back pipeline register. It selects the write-back result, commits it to a 32 x WIDTH register file, serves the decode stage's two combinational read ports with optional same-cycle write-through bypass, and keeps a committed-write counter and a last-write record for the hazard unit.

## Interface
- WIDTH, 32, data width of the register file and the write-back datapath
- WBRF_CLK  input  1  clock; all state updates on the rising edge
- WBRF_RST  input  1  reset; synchronous, active-high
- WBRF_AluOutW  input  WIDTH  ALU result from the W stage
- WBRF_ReadDataW  input  WIDTH  memory load data from the W stage
- WBRF_WriteRegW  input  5  destination register index
- WBRF_RegWriteW  input  1  register write enable
- WBRF_MemToRegW  input  1  1 selects ReadDataW, 0 selects AluOutW
- WBRF_A1  input  5  read port 1 address (rs)
- WBRF_A2  input  5  read port 2 address (rt)
- WBRF_RD1  output  WIDTH  read port 1 data
- WBRF_RD2  output  WIDTH  read port 2 data
- WBRF_ResultW  output  WIDTH  selected write-back value, for forwarding to the EX stage
- WBRF_LastWriteReg  output  5  index of the most recent committed write
- WBRF_LastWriteValid  output  1  at least one write committed since reset
- WBRF_WriteCount  output  32  committed-write counter

## Operation
- ResultW = MemToRegW ? ReadDataW : AluOutW (combinational).
- Commit condition: RegWriteW = 1 and WriteRegW != 0. On a commit edge: regs[WriteRegW] <= ResultW, LastWriteReg <= WriteRegW, LastWriteValid <= 1, WriteCount <= WriteCount + 1.
- Writes to $0 are dropped, not counted, and leave LastWrite* unchanged.
- The commit condition ignores MemToRegW.
- WriteCount wraps from 0xFFFFFFFF to 0 with no flag.
- Read ports are combinational: RDn = 0 when An = 0; otherwise the bypass value (see Configuration); otherwise regs[An].
- Both ports may read the same address, and either may match the write address. Each port resolves independently.
- Reset state: all 32 registers = 0, LastWriteReg = 0, LastWriteValid = 0, WriteCount = 0.
- RD1, RD2 and ResultW reflect inputs and reset state combinationally and have no reset value of their own.
- Reset asserted in the same cycle as a commit: reset wins, and the write is lost.

## Timing
- ResultW and RD1/RD2 have zero-cycle (combinational) latency.
- Register-file write: the value is readable from storage in the cycle after the commit edge.
- Counter and LastWrite* update on the commit edge and are visible in the next cycle.
- Reset takes effect at the first rising edge with WBRF_RST = 1. Outputs hold reset values until the first edge with WBRF_RST = 0 and a valid commit.
- There is no stall or handshake. One commit per cycle maximum, every cycle if presented.

## Configuration
- Macro: WBRF_BYPASS_EN.
- Defined: when RegWriteW = 1, WriteRegW != 0 and WriteRegW = An, RDn = ResultW in the same cycle (write-through). This removes the need for a split-phase register file.
- Undefined: RDn always returns stored regs[An]. A same-cycle read of the register being written returns the old value, and the hazard unit must stall or forward.
- The macro has no effect on counters, LastWrite*, or the $0 rule.

## Test plan
- Reset: hold WBRF_RST = 1 for 2 cycles with RegWriteW = 1, WriteRegW = 5, AluOutW = 0x1234 -> after release, A1 = 5 reads 0, WriteCount = 0, LastWriteValid = 0.
- ALU write: RegWriteW = 1, MemToRegW = 0, WriteRegW = 8, AluOutW = 0xDEADBEEF -> next cycle A1 = 8 gives RD1 = 0xDEADBEEF, WriteCount = 1, LastWriteReg = 8.
- Load write: MemToRegW = 1, ReadDataW = 0x0000CAFE, AluOutW = 0xFFFFFFFF, WriteRegW = 9 -> ResultW = 0x0000CAFE the same cycle, RD2(A2 = 9) = 0x0000CAFE the next cycle.
- $0 protection: write 0x55 to register 0 -> RD1(A1 = 0) = 0, WriteCount unchanged, LastWriteReg unchanged.
- Bypass: regs[3] = 0x11, and the current cycle writes 0x22 to 3 with A1 = A2 = 3 -> RD1 = RD2 = 0x22 with WBRF_BYPASS_EN defined, 0x11 without it. Both builds read 0x22 the next cycle.
- Counter wrap and reset collision: force WriteCount to 0xFFFFFFFF, then one commit -> 0. Then assert reset together with a write of 0x77 to register 4 -> register 4 reads 0 afterwards.
